// File: rtl/phase_noise_ctrl.sv
// Phase-impairment sequencer: settle, ramp and hold segments with
// optional LFSR jitter, one rotator angle per input sample strobe.
module phase_noise_ctrl #(
  parameter int          PW        = 16,
  parameter int          CW        = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [CW-1:0] settle_len,
  input  logic [CW-1:0] ramp_len,
  input  logic [PW-1:0] ramp_step,
  input  logic [CW-1:0] hold_len,
  input  logic          jit_en,
  input  logic [3:0]    jit_shift,
  output logic [PW-1:0] phase_out,
  output logic          phase_valid,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RAMP   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  state_t        first_seg;
  state_t        after_settle;
  state_t        after_ramp;

  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;
  logic [PW-1:0] freq_q;
  logic [PW-1:0] freq_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          pv_q;
  logic          pv_d;
  logic          done_q;
  logic          done_d;
  logic          load;

  logic [CW-1:0] settle_q;
  logic [CW-1:0] ramp_q;
  logic [CW-1:0] hold_q;
  logic [PW-1:0] step_q;
  logic          jit_en_q;
  logic [3:0]    shift_q;

  logic [CW-1:0]        seg_len;
  logic                 last;
  logic                 lfsr_fb;
  logic signed [PW-1:0] jit_ext;
  logic [PW-1:0]        jitter;
  logic [PW-1:0]        freq_up;
  logic [PW-1:0]        acc_ramp;
  logic [PW-1:0]        acc_hold;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];

  // Jitter is only ever added to the output word, never to acc.
  assign jit_ext = PW'($signed(lfsr_q));
  assign jitter  = jit_en_q ? PW'(jit_ext >>> shift_q) : '0;

  assign freq_up  = freq_q + step_q;
  assign acc_ramp = acc_q + freq_up;
  assign acc_hold = acc_q + freq_q;

  always_comb begin
    seg_len = hold_q;
    unique case (1'b1)
      (state_q == SETTLE): seg_len = settle_q;
      (state_q == RAMP):   seg_len = ramp_q;
      default:             seg_len = hold_q;
    endcase
  end

  assign last = (cnt_q == seg_len - CW'(1));

  always_comb begin
    first_seg = IDLE;
    if (settle_len != '0) begin
      first_seg = SETTLE;
    end else if (ramp_len != '0) begin
      first_seg = RAMP;
    end else if (hold_len != '0) begin
      first_seg = HOLD;
    end
  end

  assign after_settle = (ramp_q != '0) ? RAMP :
                        (hold_q != '0) ? HOLD : IDLE;
  assign after_ramp   = (hold_q != '0) ? HOLD : IDLE;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    phase_d = phase_q;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start) begin
        load    = 1'b1;
        acc_d   = '0;
        freq_d  = '0;
        cnt_d   = '0;
        lfsr_d  = LFSR_SEED;
        state_d = first_seg;
        done_d  = (first_seg == IDLE);
      end
    end else if (in_valid) begin
      pv_d  = 1'b1;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (jit_en_q) begin
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
      end
      unique case (1'b1)
        (state_q == SETTLE): begin
          phase_d = jitter;
          if (last) state_d = after_settle;
        end
        (state_q == RAMP): begin
          freq_d  = freq_up;
          acc_d   = acc_ramp;
          phase_d = acc_ramp + jitter;
          if (last) state_d = after_ramp;
        end
        default: begin
          acc_d   = acc_hold;
          phase_d = acc_hold + jitter;
          if (last) state_d = IDLE;
        end
      endcase
      done_d = last && (state_d == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      freq_q   <= '0;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      phase_q  <= '0;
      pv_q     <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= '0;
      ramp_q   <= '0;
      hold_q   <= '0;
      step_q   <= '0;
      jit_en_q <= 1'b0;
      shift_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      phase_q <= phase_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      if (load) begin
        settle_q <= settle_len;
        ramp_q   <= ramp_len;
        hold_q   <= hold_len;
        step_q   <= ramp_step;
        jit_en_q <= jit_en;
        shift_q  <= jit_shift;
      end
    end
  end

  assign phase_out   = phase_q;
  assign phase_valid = pv_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_phase_noise_ctrl.sv
// Self-checking bench for phase_noise_ctrl: closed-form profile
// model plus hand-computed literal sequences.
module tb_phase_noise_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [15:0] settle_len;
  logic [15:0] ramp_len;
  logic [15:0] ramp_step;
  logic [15:0] hold_len;
  logic        jit_en;
  logic [3:0]  jit_shift;
  logic [15:0] phase_out;
  logic        phase_valid;
  logic        busy;
  logic        done;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  phase_noise_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .settle_len (settle_len),
    .ramp_len   (ramp_len),
    .ramp_step  (ramp_step),
    .hold_len   (hold_len),
    .jit_en     (jit_en),
    .jit_shift  (jit_shift),
    .phase_out  (phase_out),
    .phase_valid(phase_valid),
    .busy       (busy),
    .done       (done),
    .state_o    (state_o)
  );

  int checks = 0;
  int passed = 0;

  logic [15:0] exp_q[$];
  logic [1:0]  st_q[$];
  logic [15:0] got_q[$];
  logic [15:0] run1_q[$];
  logic        exp_pv = 1'b0;
  logic        exp_done = 1'b0;
  logic [1:0]  exp_st = 2'd0;
  logic [15:0] exp_ph = 16'h0;
  logic        chk_en = 1'b0;

  logic [15:0] setup_lit [7] = '{16'h0000, 16'h0000, 16'h0100,
                                 16'h0300, 16'h0600, 16'h0900,
                                 16'h0C00};
  logic [15:0] wrap_lit  [6] = '{16'h4000, 16'h8000, 16'hC000,
                                 16'h0000, 16'h4000, 16'h8000};

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [1:0] seg(int m, int s, int r, int h);
    if (m < s) return 2'd1;
    if (m < s + r) return 2'd2;
    if (m < s + r + h) return 2'd3;
    return 2'd0;
  endfunction

  // Closed form: ramp sample k has acc = step*k(k+1)/2, hold adds step*r.
  task automatic build(int s, int r, logic [15:0] step, int h,
                       bit je, int sh);
    logic [15:0] l;
    logic [15:0] fr_r;
    logic [15:0] ac_r;
    logic [15:0] ph;
    logic [15:0] j;
    longint      k;
    l    = 16'hACE1;
    exp_q.delete();
    st_q.delete();
    fr_r = 16'(longint'(step) * r);
    ac_r = 16'(longint'(step) * (longint'(r) * (r + 1) / 2));
    st_q.push_back(seg(0, s, r, h));
    for (int n = 0; n < s + r + h; n++) begin
      j = je ? 16'($signed(l) >>> sh) : 16'h0;
      if (n < s) begin
        ph = 16'h0;
      end else if (n < s + r) begin
        k  = n - s + 1;
        ph = 16'(longint'(step) * (k * (k + 1) / 2));
      end else begin
        ph = 16'(longint'(ac_r) + longint'(n - s - r + 1) * fr_r);
      end
      exp_q.push_back(ph + j);
      st_q.push_back(seg(n + 1, s, r, h));
      if (je) l = lfsr_next(l);
    end
  endtask

  task automatic cfg(int s, int r, logic [15:0] step, int h,
                     bit je, int sh);
    settle_len = 16'(s);
    ramp_len   = 16'(r);
    ramp_step  = step;
    hold_len   = 16'(h);
    jit_en     = je;
    jit_shift  = 4'(sh);
    build(s, r, step, h, je, sh);
  endtask

  // One clock: drive inputs, then set what the DUT must show after it.
  task automatic tick(bit iv, bit st, bit ab);
    in_valid = iv;
    start    = st;
    abort    = ab;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    exp_pv   = 1'b0;
    exp_done = 1'b0;
    if (ab) begin
      exp_st = 2'd0;
      exp_q.delete();
      st_q.delete();
    end else if (exp_st == 2'd0) begin
      if (st && st_q.size() > 0) begin
        exp_st   = st_q.pop_front();
        exp_done = (exp_st == 2'd0);
      end
    end else if (iv && exp_q.size() > 0) begin
      exp_pv   = 1'b1;
      exp_ph   = exp_q.pop_front();
      exp_st   = st_q.pop_front();
      exp_done = (exp_st == 2'd0);
    end
  endtask

  task automatic strobes(int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b0;
    exp_pv   = 1'b0;
    exp_done = 1'b0;
    exp_st   = 2'd0;
    exp_q.delete();
    st_q.delete();
    @(negedge clk);
    check("rst_phase", 32'(phase_out), 32'h0);
  endtask

  task automatic check_setup(string nm);
    check({nm, "_count"}, 32'(got_q.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check(nm, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
            32'(setup_lit[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("phase_valid", 32'(phase_valid), 32'(exp_pv));
      check("done", 32'(done), 32'(exp_done));
      check("state", 32'(state_o), 32'(exp_st));
      check("busy", 32'(busy), 32'(exp_st != 2'd0));
      if (exp_pv) check("phase", 32'(phase_out), 32'(exp_ph));
      if (phase_valid) got_q.push_back(phase_out);
    end
  end

  initial begin
    int zeros;
    int ones;
    int diffs;
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    cfg(0, 0, 16'h0, 0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    // Basic profile, with a start and config churn while busy
    cfg(2, 3, 16'h0100, 2, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    ramp_step  = 16'h9999;
    settle_len = 16'd7;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    strobes(4);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_setup("setup_seq");

    // Modulo wrap of acc
    cfg(0, 1, 16'h4000, 5, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(6);
    tick(1'b0, 1'b0, 1'b0);
    check("wrap_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check("wrap_seq",
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
            32'(wrap_lit[i]));

    // Abort on the 2nd ramp sample
    cfg(2, 3, 16'h0100, 2, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(3);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("abort_count", 32'(got_q.size()), 32'd3);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    build(2, 3, 16'h0100, 2, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(7);
    tick(1'b0, 1'b0, 1'b0);
    check_setup("rerun_seq");

    // All lengths zero
    cfg(0, 0, 16'h0100, 0, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("zero_count", 32'(got_q.size()), 32'd0);

    // Jitter, two identical runs
    cfg(1000, 0, 16'h0, 0, 1'b1, 15);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(1000);
    tick(1'b0, 1'b0, 1'b0);
    run1_q = got_q;
    zeros  = 0;
    ones   = 0;
    foreach (run1_q[i]) begin
      if (run1_q[i] == 16'h0000) zeros++;
      if (run1_q[i] == 16'hFFFF) ones++;
    end
    check("jit_count", 32'(run1_q.size()), 32'd1000);
    check("jit_set", 32'(zeros + ones), 32'(run1_q.size()));
    check("jit_both", 32'(zeros > 0 && ones > 0), 32'd1);
    build(1000, 0, 16'h0, 0, 1'b1, 15);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(1000);
    tick(1'b0, 1'b0, 1'b0);
    diffs = (got_q.size() == run1_q.size()) ? 0 : 1;
    foreach (run1_q[i])
      if (i < got_q.size() && got_q[i] != run1_q[i]) diffs++;
    check("jit_repeat", 32'(diffs), 32'd0);

    // Reset in HOLD, then a clean re-run
    cfg(2, 3, 16'h0100, 2, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(5);
    do_reset();
    tick(1'b0, 1'b0, 1'b0);
    build(2, 3, 16'h0100, 2, 1'b0, 0);
    got_q.delete();
    tick(1'b0, 1'b1, 1'b0);
    strobes(7);
    tick(1'b0, 1'b0, 1'b0);
    check_setup("post_reset_seq");

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
